bsg_lru_pseudo_tree_tracker: RTL

- Per-set pseudo-tree LRU state store with victim selection.
- Write side: hit/fill updates mark a way MRU, using the same path bits the pseudo-tree decoder generates (data/mask).
- Read side: a query walks a set's tree and returns the LRU victim way. This is the encode direction of the decoder.
- Sits beside cache tag arrays. The miss handler queries it for a victim; the hit path updates it.

---
 rtl/bsg_lru_pseudo_tree_tracker.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// ---------------------------------------------------------------------------
// bsg_lru_pseudo_tree_tracker : per-set pseudo-tree LRU store with victim query
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_lru_pseudo_tree_tracker #(
  parameter int ways_p       = 16,
  parameter int sets_p       = 64,
  parameter int auto_touch_p = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  input  logic [$clog2(sets_p)-1:0]   set_i,
  output logic                        ready_o,
  output logic                        v_o,
  output logic [$clog2(ways_p)-1:0]   way_o,
  input  logic                        yumi_i,
  input  logic                        upd_v_i,
  input  logic [$clog2(sets_p)-1:0]   upd_set_i,
  input  logic [$clog2(ways_p)-1:0]   upd_way_i,
  output logic                        init_done_o
);

  localparam int lg_ways = $clog2(ways_p);
  localparam int lg_sets = $clog2(sets_p);

  typedef logic [ways_p-2:0]  tree_t;
  typedef logic [lg_ways-1:0] way_t;
  typedef logic [lg_ways-1:0] node_t;
  typedef logic [lg_sets-1:0] set_t;

  typedef enum logic [0:0] {INIT = 1'b0, READY = 1'b1} state_e;

  // Node on level l of way w's path is (2^l - 1) plus the top l bits of w.
  function automatic tree_t apply_mru(input tree_t b, input way_t w);
    tree_t r;
    node_t n;
    logic  d;
    r = b;
    for (int l = 0; l < lg_ways; l++) begin
      n    = node_t'((1 << l) - 1 + int'(w >> (lg_ways - l)));
      d    = 1'(w >> (lg_ways - 1 - l));
      r[n] = ~d;
    end
    return r;
  endfunction

  function automatic way_t find_victim(input tree_t b);
    way_t  v;
    node_t n;
    v = '0;
    for (int l = 0; l < lg_ways; l++) begin
      n = node_t'((1 << l) - 1 + int'(v));
      v = way_t'({v, b[n]});
    end
    return v;
  endfunction

  state_e state_r;
  set_t   sweep_r;
  set_t   resp_set_r;
  tree_t  bits_r    [sets_p];
  tree_t  bits_next [sets_p];

  logic touch_en;
  logic upd_en;
  logic accept;

  assign touch_en    = (auto_touch_p != 0) && v_o && yumi_i;
  assign upd_en      = (state_r == READY) && upd_v_i;
  assign ready_o     = (state_r == READY) && (~v_o || yumi_i);
  assign accept      = v_i && ready_o;
  assign init_done_o = (state_r == READY);

  // Touch applies first so an overlapping update wins shared path bits.
  always_comb begin
    for (int s = 0; s < sets_p; s++) begin
      bits_next[s] = bits_r[s];
      if (touch_en && resp_set_r == set_t'(s))
        bits_next[s] = apply_mru(bits_next[s], way_o);
      if (upd_en && upd_set_i == set_t'(s))
        bits_next[s] = apply_mru(bits_next[s], upd_way_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= INIT;
      sweep_r    <= '0;
      v_o        <= 1'b0;
      way_o      <= '0;
      resp_set_r <= '0;
    end else begin
      case (state_r)
        INIT: begin
          bits_r[sweep_r] <= '0;
          sweep_r         <= sweep_r + 1'b1;
          if (sweep_r == set_t'(sets_p - 1))
            state_r <= READY;
        end
        READY: begin
          bits_r <= bits_next;
          if (accept) begin
            v_o        <= 1'b1;
            way_o      <= find_victim(bits_next[set_i]);
            resp_set_r <= set_i;
          end else if (yumi_i) begin
            v_o <= 1'b0;
          end
        end
        default: state_r <= INIT;
      endcase
    end
  end

endmodule

`default_nettype wire
